// File: rtl/ioctl_dispatch.sv
// Routes the HPS download stream to the core ROM port, the mod one-hot bus and the DIP registers, and sequences core_reset.
// Optional rom_sum checksum output when LOADER_CHECKSUM_EN is defined. ROM writes have 1-cycle latency; no backpressure.
module ioctl_dispatch #(
  parameter int ROM_AW        = 16,
  parameter int NUM_MODS      = 18,
  parameter int DIP_BYTES     = 8,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic [ROM_AW-1:0]      dn_addr,
  output logic [7:0]             dn_data,
  output logic                   dn_wr,
  output logic [7:0]             mod_code,
  output logic [NUM_MODS-1:0]    mod_onehot,
  output logic [8*DIP_BYTES-1:0] dip_flat,
  output logic                   core_reset,
  output logic                   rom_loaded,
  output logic                   oob_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]            rom_sum
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_ROM, LOAD_MOD, LOAD_DIP, IGNORE, SETTLE, RUN
  } state_t;

  state_t             state;
  state_t             ret_state;
  logic               dl_prev;
  logic [CNT_W-1:0]   settle_cnt;

  logic               dl_rise;
  logic               rom_in_range;
  logic [7:0]         mod_next;
  logic [NUM_MODS-1:0] onehot_next;

  assign dl_rise      = ioctl_download & ~dl_prev;
  assign rom_in_range = (ioctl_addr[24:ROM_AW] == '0);

  // A mod byte arriving in the same cycle the download falls must still reach the one-hot bus.
  always_comb begin
    mod_next = mod_code;
    if (state == LOAD_MOD && ioctl_wr && ioctl_addr == 25'd0)
      mod_next = ioctl_dout;
    onehot_next = '0;
    for (int k = 0; k < NUM_MODS; k++)
      onehot_next[k] = (mod_next == 8'(k));
    if (32'(mod_next) >= NUM_MODS)
      onehot_next = NUM_MODS'(1);
  end

  function automatic state_t dispatch(input logic [7:0] idx);
    case (idx)
      8'd0:    return LOAD_ROM;
      8'd1:    return LOAD_MOD;
      8'd254:  return LOAD_DIP;
      default: return IGNORE;
    endcase
  endfunction

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      dl_prev    <= 1'b0;
      settle_cnt <= '0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      mod_code   <= '0;
      mod_onehot <= NUM_MODS'(1);
      dip_flat   <= '1;
      core_reset <= 1'b1;
      rom_loaded <= 1'b0;
      oob_err    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      rom_sum    <= '0;
`endif
    end else begin
      dl_prev <= ioctl_download;
      dn_wr   <= 1'b0;
      case (state)
        IDLE, RUN, SETTLE: begin
          if (dl_rise) begin
            // Index is captured here only; the load state itself holds it until download falls.
            state      <= dispatch(ioctl_index);
            ret_state  <= state;
            settle_cnt <= '0;
            if (ioctl_index == 8'd0 || ioctl_index == 8'd1)
              core_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (ioctl_index == 8'd0)
              rom_sum <= '0;
`endif
          end else if (state == SETTLE) begin
            if (settle_cnt == CNT_LAST) begin
              settle_cnt <= '0;
              state      <= rom_loaded ? RUN : IDLE;
              core_reset <= ~rom_loaded;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end else if (state == IDLE) begin
            core_reset <= 1'b1;
          end else begin
            core_reset <= 1'b0;
          end
        end

        LOAD_ROM: begin
          core_reset <= 1'b1;
          if (ioctl_wr) begin
            if (rom_in_range) begin
              dn_wr   <= 1'b1;
              dn_addr <= ioctl_addr[ROM_AW-1:0];
              dn_data <= ioctl_dout;
`ifdef LOADER_CHECKSUM_EN
              rom_sum <= rom_sum + {8'd0, ioctl_dout};
`endif
            end else begin
              oob_err <= 1'b1;
            end
          end
          if (!ioctl_download) begin
            rom_loaded <= 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end

        LOAD_MOD: begin
          core_reset <= 1'b1;
          mod_code   <= mod_next;
          if (!ioctl_download) begin
            mod_onehot <= onehot_next;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end

        LOAD_DIP: begin
          if (ioctl_wr) begin
            for (int i = 0; i < DIP_BYTES; i++)
              if (ioctl_addr == 25'(i))
                dip_flat[8*i +: 8] <= ioctl_dout;
          end
          if (!ioctl_download)
            state <= ret_state;
        end

        IGNORE: begin
          if (!ioctl_download)
            state <= ret_state;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_dispatch.sv
// Directed bench: ROM writes go through a scoreboard queue checked by a dn_wr monitor; other outputs are checked inline.
module tb_ioctl_dispatch;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [7:0]  mod_code;
  logic [17:0] mod_onehot;
  logic [63:0] dip_flat;
  logic        core_reset;
  logic        rom_loaded;
  logic        oob_err;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  ioctl_dispatch dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .mod_code(mod_code), .mod_onehot(mod_onehot), .dip_flat(dip_flat),
    .core_reset(core_reset), .rom_loaded(rom_loaded), .oob_err(oob_err)
`ifdef LOADER_CHECKSUM_EN
    , .rom_sum(rom_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } rom_wr_t;

  rom_wr_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every dn_wr pulse must match the oldest expected write, one cycle after its strobe.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && dn_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dn_wr_unexpected actual addr=%h data=%h required no write", dn_addr, dn_data);
      end else begin
        rom_wr_t e;
        e = exp_q.pop_front();
        chk("dn_addr", 64'(dn_addr), 64'(e.addr));
        chk("dn_data", 64'(dn_data), 64'(e.data));
        chk("dn_latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit exp, input bit last = 1'b0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (last) ioctl_download = 1'b0;
    if (exp) exp_q.push_back('{addr: a[15:0], data: d, cyc: cyc + 1});
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Counts cycles core_reset stays high from now; bounded so a stuck reset still reaches the summary.
  task automatic count_settle(input string name, input int exp_n);
    int n = 0;
    while (core_reset === 1'b1 && n < 10000) begin
      n++;
      tick();
    end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_mod_onehot", 64'(mod_onehot), 64'h00001);
    chk("rst_dip_flat", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_dn_wr", 64'(dn_wr), 64'd0);
    chk("rst_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_oob_err", 64'(oob_err), 64'd0);
    chk("rst_mod_code", 64'(mod_code), 64'd0);
    tick();

    // Basic ROM load, then the settle window.
    start_dl(8'd0);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(i), 1'b1);
    wr_byte(25'h0FFFF, 8'h3C, 1'b1);
    tick();
    wr_byte(25'h00123, 8'hA5, 1'b1);
    end_dl();
    chk("rom_loaded_after_load", 64'(rom_loaded), 64'd1);
    count_settle("settle_len_first", 4096);
    chk("run_core_reset", 64'(core_reset), 64'd0);

    // Out-of-range byte, plus a byte in the same cycle as download falling.
    start_dl(8'd0);
    chk("reload_core_reset", 64'(core_reset), 64'd1);
    wr_byte(25'h10000, 8'hEE, 1'b0);
    wr_byte(25'h00005, 8'h77, 1'b1);
    wr_byte(25'h00006, 8'h88, 1'b1, 1'b1);
    chk("oob_err_set", 64'(oob_err), 64'd1);

    // Rising 100 cycles into settle restarts the count; mod byte 0x0B wins over 0x05.
    repeat (100) tick();
    start_dl(8'd1);
    wr_byte(25'h0, 8'h0B, 1'b0);
    wr_byte(25'h1, 8'h05, 1'b0);
    end_dl();
    chk("mod_code_0b", 64'(mod_code), 64'h0B);
    chk("mod_onehot_bit11", 64'(mod_onehot), 64'h00800);
    count_settle("settle_len_restart", 4096);
    chk("oob_err_sticky", 64'(oob_err), 64'd1);

    // Out-of-range mod value falls back to variant 0.
    start_dl(8'd1);
    wr_byte(25'h0, 8'h20, 1'b0);
    end_dl();
    chk("mod_code_20", 64'(mod_code), 64'h20);
    chk("mod_onehot_fallback", 64'(mod_onehot), 64'h00001);
    count_settle("settle_len_mod", 4096);

    // DIP edits while running must not reset the core.
    start_dl(8'd254);
    chk("dip_core_reset_start", 64'(core_reset), 64'd0);
    wr_byte(25'h2, 8'h5A, 1'b0);
    wr_byte(25'h9, 8'h00, 1'b0);
    ioctl_index = 8'd0;
    wr_byte(25'h3, 8'h11, 1'b0);
    chk("dip_core_reset_mid", 64'(core_reset), 64'd0);
    end_dl();
    repeat (3) tick();
    chk("dip_flat_bytes", dip_flat, 64'hFFFF_FFFF_115A_FFFF);
    chk("dip_core_reset_after", 64'(core_reset), 64'd0);

    // Unknown index is discarded entirely.
    start_dl(8'd7);
    wr_byte(25'h0, 8'h44, 1'b0);
    wr_byte(25'h2, 8'h44, 1'b0);
    end_dl();
    repeat (3) tick();
    chk("ignore_dip_flat", dip_flat, 64'hFFFF_FFFF_115A_FFFF);
    chk("ignore_core_reset", 64'(core_reset), 64'd0);
    chk("ignore_mod_code", 64'(mod_code), 64'h20);

    // Checksum load: three 0xFF in range, one out of range.
    start_dl(8'd0);
    wr_byte(25'h0, 8'hFF, 1'b1);
    wr_byte(25'h1, 8'hFF, 1'b1);
    wr_byte(25'h20000, 8'hFF, 1'b0);
    wr_byte(25'h2, 8'hFF, 1'b1, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    chk("rom_sum", 64'(rom_sum), 64'h02FD);
`endif
    chk("oob_err_after_clean", 64'(oob_err), 64'd1);
    count_settle("settle_len_sum", 4096);

    // Reset mid-load discards the load state.
    start_dl(8'd0);
    wr_byte(25'h40, 8'h12, 1'b1);
    tick();
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("midrst_rom_loaded", 64'(rom_loaded), 64'd0);
    chk("midrst_oob_err", 64'(oob_err), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_dip_flat", dip_flat, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) tick();

    chk("dn_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
